conv_layer_sched: RTL and testbench

//  Top-level sequencer for the conv accelerator. For each layer it loads weights and the input map,

---
 rtl/acc_pkg.sv | 36 +++
 rtl/sched_watchdog.sv | 30 +++
 rtl/conv_layer_sched.sv | 128 ++++++++++++
 tb/tb_conv_layer_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the conv accelerator scheduler: state encoding,
// DMA opcodes and default widths.
package acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_ILOAD,
    S_CONV,
    S_WB,
    S_NEXT,
    S_ERR
  } sched_state_t;

  localparam logic [1:0] DMA_OP_WLOAD = 2'd0;
  localparam logic [1:0] DMA_OP_ILOAD = 2'd1;
  localparam logic [1:0] DMA_OP_WB    = 2'd2;

  localparam int LAYER_W_DEF = 4;
  localparam int ADDR_W_DEF  = 32;
  localparam int TMO_W_DEF   = 20;

  // States in which the scheduler is waiting on an external party.
  function automatic logic is_wait_state(sched_state_t s);
    return (s == S_WLOAD) || (s == S_ILOAD) || (s == S_CONV) || (s == S_WB);
  endfunction

  function automatic logic is_dma_state(sched_state_t s);
    return (s == S_WLOAD) || (s == S_ILOAD) || (s == S_WB);
  endfunction

  function automatic logic is_busy_state(sched_state_t s);
    return (s != S_IDLE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// the cycle whose count completes 2**TMO_W-1 cycles.
module sched_watchdog
  import acc_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(2**TMO_W - 2);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted while the current cycle brings the count to its limit.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/conv_layer_sched.sv
// Per-job layer sequencer: weight/imap loads, MAC-array start, output
// writeback, repeated for a programmed number of layers.
module conv_layer_sched
  import acc_pkg::*;
#(
  parameter int LAYER_W = LAYER_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_start,
  input  logic               job_abort,
  input  logic [LAYER_W-1:0] cfg_num_layer,
  input  logic [ADDR_W-1:0]  cfg_wbase,
  input  logic [ADDR_W-1:0]  cfg_wstride,
  input  logic [ADDR_W-1:0]  cfg_ibase,
  input  logic [ADDR_W-1:0]  cfg_obase,
  output logic               dma_req,
  output logic [1:0]         dma_op,
  output logic [ADDR_W-1:0]  dma_addr,
  input  logic               dma_ack,
  output logic               conv_start,
  input  logic               conv_done,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               job_done,
  output logic               err_tmo
);

  sched_state_t       state, state_nx;
  logic [LAYER_W-1:0] num_layer;
  logic [ADDR_W-1:0]  waddr, wstride, ibase, obase;
  logic               ack_ok, accept, last_layer, advance;
  logic               wd_expired;

  // An ack only counts against an outstanding request.
  assign ack_ok     = dma_ack && dma_req;
  assign accept     = (state == S_IDLE) && job_start && !job_abort;
  assign last_layer = (layer_idx == num_layer - 1'b1);
  assign advance    = (state == S_NEXT) && !job_abort && !last_layer;

  sched_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_nx != state),
    .en      (is_wait_state(state)),
    .expired (wd_expired)
  );

  always_comb begin
    state_nx = state;
    if (job_abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (job_start && (cfg_num_layer != '0)) state_nx = S_WLOAD;
        S_WLOAD: if (ack_ok) state_nx = (layer_idx == '0) ? S_ILOAD : S_CONV;
        S_ILOAD: if (ack_ok) state_nx = S_CONV;
        S_CONV:  if (conv_done) state_nx = S_WB;
        S_WB:    if (ack_ok) state_nx = S_NEXT;
        S_NEXT:  state_nx = last_layer ? S_IDLE : S_WLOAD;
        S_ERR:   if (job_start) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
      // Progress in the same cycle beats the watchdog.
      if (wd_expired && (state_nx == state)) state_nx = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      layer_idx  <= '0;
      busy       <= 1'b0;
      job_done   <= 1'b0;
      conv_start <= 1'b0;
      dma_req    <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= is_busy_state(state_nx);
      job_done   <= (accept && (cfg_num_layer == '0)) ||
                    ((state == S_NEXT) && last_layer && !job_abort);
      conv_start <= (state_nx == S_CONV) && (state != S_CONV);
      // Clearing on the ack forces one idle cycle before the next request.
      dma_req    <= is_dma_state(state_nx) && !ack_ok;
      if (accept) begin
        layer_idx <= '0;
        err_tmo   <= 1'b0;
      end else if (advance) begin
        layer_idx <= layer_idx + 1'b1;
      end
      if ((state_nx == S_ERR) && (state != S_ERR)) err_tmo <= 1'b1;
    end
  end

  // Weight address is accumulated per layer instead of multiplied.
  always_ff @(posedge clk) begin
    if (accept) begin
      num_layer <= cfg_num_layer;
      waddr     <= cfg_wbase;
      wstride   <= cfg_wstride;
      ibase     <= cfg_ibase;
      obase     <= cfg_obase;
    end else if (advance) begin
      waddr <= waddr + wstride;
    end
  end

  always_comb begin
    dma_op   = DMA_OP_WLOAD;
    dma_addr = '0;
    case (state)
      S_WLOAD: dma_addr = waddr;
      S_ILOAD: begin
        dma_op   = DMA_OP_ILOAD;
        dma_addr = ibase;
      end
      S_WB: begin
        dma_op   = DMA_OP_WB;
        dma_addr = obase;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed and randomized checks of conv_layer_sched against an expected
// per-job transaction list built from the layer sequencing rules.
module tb_conv_layer_sched;
  import acc_pkg::*;

  localparam int LAYER_W = 4;
  localparam int ADDR_W  = 32;
  localparam int TMO_W   = 4;

  logic               clk = 1'b0;
  logic               rst, job_start, job_abort;
  logic [LAYER_W-1:0] cfg_num_layer;
  logic [ADDR_W-1:0]  cfg_wbase, cfg_wstride, cfg_ibase, cfg_obase;
  logic               dma_req, dma_ack, conv_start, conv_done;
  logic [1:0]         dma_op;
  logic [ADDR_W-1:0]  dma_addr;
  logic [LAYER_W-1:0] layer_idx;
  logic               busy, job_done, err_tmo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 = DMA transfer, 1 = conv_start
    logic [1:0]  op;
    logic [31:0] addr;
    int          lidx;
  } ev_t;

  conv_layer_sched #(.LAYER_W(LAYER_W), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .job_start     (job_start),
    .job_abort     (job_abort),
    .cfg_num_layer (cfg_num_layer),
    .cfg_wbase     (cfg_wbase),
    .cfg_wstride   (cfg_wstride),
    .cfg_ibase     (cfg_ibase),
    .cfg_obase     (cfg_obase),
    .dma_req       (dma_req),
    .dma_op        (dma_op),
    .dma_addr      (dma_addr),
    .dma_ack       (dma_ack),
    .conv_start    (conv_start),
    .conv_done     (conv_done),
    .layer_idx     (layer_idx),
    .busy          (busy),
    .job_done      (job_done),
    .err_tmo       (err_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   dma_req,    1'b0);
    check({tag, "_cs"},    conv_start, 1'b0);
    check({tag, "_busy"},  busy,       1'b0);
    check({tag, "_done"},  job_done,   1'b0);
  endtask

  // Runs one job with a DMA/MAC responder; dlat/clat < 0 picks random latencies.
  task automatic run_job(input int n, input logic [31:0] wb, ws, ib, ob,
                         input int dlat, input int clat, input bit noise, input int abort_at);
    ev_t         q[$];
    ev_t         e;
    logic [31:0] a;
    int          dcnt = -1, ccnt = -1, cyc = 0, dones = 0;
    bit          in_conv = 0, aborted = 0, stop = 0, prev_ack = 0;
    for (int l = 0; l < n; l++) begin
      a = wb + ws * 32'(l);
      e = '{kind: 0, op: DMA_OP_WLOAD, addr: a, lidx: l};  q.push_back(e);
      if (l == 0) begin
        e = '{kind: 0, op: DMA_OP_ILOAD, addr: ib, lidx: 0}; q.push_back(e);
      end
      e = '{kind: 1, op: 2'd0, addr: 32'd0, lidx: l};     q.push_back(e);
      e = '{kind: 0, op: DMA_OP_WB, addr: ob, lidx: l};    q.push_back(e);
    end
    cfg_num_layer = LAYER_W'(n);
    cfg_wbase = wb; cfg_wstride = ws; cfg_ibase = ib; cfg_obase = ob;
    job_start = 1'b1;
    @(negedge clk);
    while (!stop && !aborted && cyc < 3000) begin
      cyc++;
      job_start = 1'b0; job_abort = 1'b0; dma_ack = 1'b0; conv_done = 1'b0;
      if (job_done) begin
        dones++;
        check("done_queue_empty", q.size(), 0);
        check("done_layer_idx", layer_idx, LAYER_W'(n - 1));
        check("done_busy", busy, 1'b0);
        break;
      end
      check("busy_in_job", busy, 1'b1);
      if (prev_ack) check("req_gap_after_ack", dma_req, 1'b0);
      prev_ack = 1'b0;
      if (dma_req) begin
        if (q.size() == 0 || q[0].kind != 0) begin
          check("unexpected_dma_req", dma_op, 2'd3);
          stop = 1;
        end else begin
          check("dma_op", dma_op, q[0].op);
          check("dma_addr", dma_addr, q[0].addr);
          check("dma_layer_idx", layer_idx, LAYER_W'(q[0].lidx));
          if (dcnt < 0) dcnt = (dlat < 0) ? int'($urandom_range(0, 4)) : dlat;
          if (dcnt == 0) begin
            dma_ack = 1'b1; prev_ack = 1'b1; dcnt = -1;
            void'(q.pop_front());
          end else dcnt--;
        end
      end
      if (conv_start) begin
        if (q.size() == 0 || q[0].kind != 1) begin
          check("unexpected_conv_start", layer_idx, 4'hF);
          stop = 1;
        end else begin
          check("conv_layer_idx", layer_idx, LAYER_W'(q[0].lidx));
          if (q[0].lidx == abort_at) begin
            job_abort = 1'b1;
            aborted = 1;
          end else begin
            ccnt = (clat < 0) ? int'($urandom_range(0, 5)) : clat;
            in_conv = 1;
          end
          void'(q.pop_front());
        end
      end
      if (in_conv) begin
        if (ccnt == 0) begin
          conv_done = 1'b1; in_conv = 0;
        end else begin
          ccnt--;
          if (noise && $urandom_range(0, 1) == 1) dma_ack = 1'b1;
        end
      end
      if (noise) begin
        cfg_num_layer = LAYER_W'($urandom);
        cfg_wbase = $urandom; cfg_wstride = $urandom;
        cfg_ibase = $urandom; cfg_obase = $urandom;
        if (busy && $urandom_range(0, 2) == 0) job_start = 1'b1;
      end
      @(negedge clk);
    end
    job_start = 1'b0; job_abort = 1'b0; dma_ack = 1'b0; conv_done = 1'b0;
    if (aborted) begin
      check("abort_busy", busy, 1'b0);
      check("abort_req", dma_req, 1'b0);
      check("abort_layer_kept", layer_idx, LAYER_W'(abort_at));
      check("abort_done", job_done, 1'b0);
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check_idle_outputs("post_abort");
        @(negedge clk);
      end
    end else begin
      check("job_done_seen", dones, 1);
      @(negedge clk);
      check("done_single_pulse", job_done, 1'b0);
      check("idle_after_done", busy, 1'b0);
    end
  endtask

  // Starts a job whose weight load is never acknowledged; returns in ERR.
  task automatic run_timeout();
    int reqc = 0;
    cfg_num_layer = 4'd2; cfg_wbase = 32'h4000; cfg_wstride = 32'h10;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    while (dma_req && reqc < 40) begin
      check("tmo_req_op", dma_op, DMA_OP_WLOAD);
      reqc++;
      @(negedge clk);
    end
    check("tmo_wload_cycles", reqc, 15);
    check("tmo_err_flag", err_tmo, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_req", dma_req, 1'b0);
  endtask

  initial begin
    rst = 1'b1; job_start = 1'b0; job_abort = 1'b0; dma_ack = 1'b0; conv_done = 1'b0;
    cfg_num_layer = '0; cfg_wbase = '0; cfg_wstride = '0; cfg_ibase = '0; cfg_obase = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_op", dma_op, 2'd0);
    check("reset_addr", dma_addr, 32'd0);
    check("reset_layer", layer_idx, 4'd0);
    check("reset_err", err_tmo, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Three layers, fixed 5-cycle DMA latency.
    run_job(3, 32'h1000, 32'h200, 32'h8000, 32'h9000, 5, 2, 1'b0, -1);

    // Zero-layer job completes on the next cycle with no traffic.
    cfg_num_layer = '0;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("n0_done", job_done, 1'b1);
    check("n0_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("n0_quiet");
    end

    // Timeout, left via abort; a zero-layer job then proves IDLE and clears the flag.
    run_timeout();
    job_abort = 1'b1;
    @(negedge clk);
    job_abort = 1'b0;
    check("err_abort_sticky", err_tmo, 1'b1);
    cfg_num_layer = '0;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("err_abort_then_done", job_done, 1'b1);
    check("err_cleared_by_start", err_tmo, 1'b0);
    @(negedge clk);

    // Timeout, left via job_start, which must not start a job.
    run_timeout();
    cfg_num_layer = '0;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("err_start_not_accepted", job_done, 1'b0);
    check("err_start_sticky", err_tmo, 1'b1);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("idle_after_err_start", job_done, 1'b1);
    @(negedge clk);

    // Abort in CONV of layer 1.
    run_job(3, 32'h2000, 32'h100, 32'hA000, 32'hB000, -1, -1, 1'b0, 1);

    // Busy-time job_start, cfg churn and stray acks in CONV.
    run_job(3, 32'h1000, 32'h200, 32'h8000, 32'h9000, -1, 3, 1'b1, -1);

    // conv_done coincident with conv_start.
    run_job(2, 32'h3000, 32'h40, 32'hC000, 32'hD000, 1, 0, 1'b0, -1);

    // Weight address wraps modulo 2**32.
    run_job(4, 32'hFFFF_F800, 32'h400, 32'h100, 32'h200, -1, -1, 1'b0, -1);

    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(1, 6)), $urandom, $urandom, $urandom, $urandom,
              -1, -1, 1'($urandom_range(0, 1)), -1);
    end

    // Reset in the middle of a job.
    cfg_num_layer = 4'd2; cfg_wbase = 32'h500; cfg_wstride = 32'h10;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");
    check("midrst_layer", layer_idx, 4'd0);
    check("midrst_addr", dma_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("post_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
